// File: rtl/elapsed_timer_pkg.sv
// elapsed_timer_pkg
// Shared types and constants for the elapsed_timer block.
//   state_t          : FSM state encoding (IDLE, RUN, HOLD)
//   ET_N_DEFAULT     : default counter/result width
//   ET_ALL_ONES      : saturation value for the default width
// Optional feature macro used by the block: ELAPSED_TIMEOUT_EN.
package elapsed_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int unsigned ET_N_DEFAULT = 10;

  // Saturation value for the default width, built from the width itself.
  localparam logic [ET_N_DEFAULT-1:0] ET_ALL_ONES = {ET_N_DEFAULT{1'b1}};

endpackage

// File: rtl/sat_up_counter.sv
// sat_up_counter
// Saturating up-counter owned by elapsed_timer.
// Ports:
//   clk   in   system clock
//   reset in   asynchronous active-low reset
//   clr   in   synchronous clear to zero (wins over inc)
//   inc   in   advance by one unless already saturated
//   q     out  N-bit count
//   sat   out  count is all-ones
module sat_up_counter
  import elapsed_timer_pkg::*;
#(
  parameter int N = ET_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [N-1:0] q,
  output logic         sat
);

  localparam logic [N-1:0] MAX_COUNT = {N{1'b1}};

  assign sat = (q == MAX_COUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !sat) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/elapsed_timer.sv
// elapsed_timer
// Counts qualified ticks between a start pulse and a stop pulse and holds the
// captured value behind a valid/ready handshake until the consumer takes it.
//
// Handshake: result is transferred on a cycle where result_valid and
// result_ready are both high; result_valid never drops before that transfer
// except on clear or reset, and result stays stable while result_valid is high.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   en           in   tick qualifier
//   start        in   begin measurement (IDLE only; wins over stop)
//   stop         in   end measurement, capture count
//   clear        in   synchronous abort to IDLE
//   count        out  live counter value
//   result       out  captured measurement
//   result_valid out  result available
//   result_ready in   consumer accepts result
//   overflow     out  counter saturated during this measurement (sticky)
//   busy         out  high in RUN
//   timeout_val  in   auto-stop threshold   (ELAPSED_TIMEOUT_EN only)
//   timed_out    out  measurement auto-stopped (ELAPSED_TIMEOUT_EN only)
//   fsm_state    out  current FSM state, for observation
// Optional feature macro: ELAPSED_TIMEOUT_EN.
module elapsed_timer
  import elapsed_timer_pkg::*;
#(
  parameter int N = ET_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  output logic [N-1:0] count,
  output logic [N-1:0] result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         overflow,
  output logic         busy,
`ifdef ELAPSED_TIMEOUT_EN
  input  logic [N-1:0] timeout_val,
  output logic         timed_out,
`endif
  output state_t       fsm_state
);

  state_t state;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_sat;
  logic   tick_run;
  logic   timeout_hit;

  // A stop cycle ignores en so the captured value equals the held count.
  assign tick_run = (state == ST_RUN) && en && !stop;

`ifdef ELAPSED_TIMEOUT_EN
  assign timeout_hit = tick_run && (count == timeout_val);
`else
  assign timeout_hit = 1'b0;
`endif

  assign cnt_clr = clear || ((state == ST_IDLE) && start);
  assign cnt_inc = tick_run && !timeout_hit;

  sat_up_counter #(.N(N)) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .q     (count),
    .sat   (cnt_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
`ifdef ELAPSED_TIMEOUT_EN
      timed_out    <= 1'b0;
`endif
    end else if (clear) begin
      state        <= ST_IDLE;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
`ifdef ELAPSED_TIMEOUT_EN
      timed_out    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            overflow <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state        <= ST_HOLD;
            result       <= count;
            result_valid <= 1'b1;
            busy         <= 1'b0;
          end else if (timeout_hit) begin
            state        <= ST_HOLD;
            result       <= count;
            result_valid <= 1'b1;
            busy         <= 1'b0;
`ifdef ELAPSED_TIMEOUT_EN
            timed_out    <= 1'b1;
`endif
          end else if (en && cnt_sat) begin
            overflow <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (result_ready) begin
            state        <= ST_IDLE;
            result_valid <= 1'b0;
`ifdef ELAPSED_TIMEOUT_EN
            timed_out    <= 1'b0;
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_elapsed_timer.sv
// tb_elapsed_timer
// Directed bench for elapsed_timer: a default-width (N=10) instance and a
// narrow (N=4) instance share all inputs; the narrow one covers saturation.
// Optional feature macro exercised when defined: ELAPSED_TIMEOUT_EN.
module tb_elapsed_timer;
  import elapsed_timer_pkg::*;

  logic clk = 1'b0;
  logic reset, en, start, stop, clear, result_ready;

  logic [9:0] count10, result10;
  logic       valid10, overflow10, busy10;
  state_t     state10;
  logic [3:0] count4, result4;
  logic       valid4, overflow4, busy4;
  state_t     state4;
`ifdef ELAPSED_TIMEOUT_EN
  logic [9:0] tv;
  logic       timed_out10, timed_out4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elapsed_timer #(.N(10)) dut10 (
    .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop), .clear(clear),
    .count(count10), .result(result10), .result_valid(valid10),
    .result_ready(result_ready), .overflow(overflow10), .busy(busy10),
`ifdef ELAPSED_TIMEOUT_EN
    .timeout_val(tv), .timed_out(timed_out10),
`endif
    .fsm_state(state10)
  );

  elapsed_timer #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop), .clear(clear),
    .count(count4), .result(result4), .result_valid(valid4),
    .result_ready(result_ready), .overflow(overflow4), .busy(busy4),
`ifdef ELAPSED_TIMEOUT_EN
    .timeout_val(tv[3:0]), .timed_out(timed_out4),
`endif
    .fsm_state(state4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    result_ready = 1'b0;
`ifdef ELAPSED_TIMEOUT_EN
    tv = 10'h3ff;
`endif
    step();
    step();
    checks++; if (count10 !== 10'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count10); end
    checks++; if (result10 !== 10'd0) begin errors++; $display("FAIL reset_result: got %0d exp 0", result10); end
    checks++; if ({valid10, overflow10, busy10} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {valid10, overflow10, busy10}); end
    checks++; if (state10 !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", state10, ST_IDLE); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy10 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", busy10); end
    checks++; if (state10 !== ST_RUN) begin errors++; $display("FAIL basic_state_run: got %0d exp %0d", state10, ST_RUN); end
    en = 1'b1;
    for (int i = 0; i < 25; i++) step();
    checks++; if (count10 !== 10'd25) begin errors++; $display("FAIL basic_count: got %0d exp 25", count10); end
    stop = 1'b1;
    checks++; if (valid10 !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b exp 0", valid10); end
    step();
    stop = 1'b0; en = 1'b0;
    checks++; if (valid10 !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", valid10); end
    checks++; if (result10 !== 10'd25) begin errors++; $display("FAIL basic_result: got %0d exp 25", result10); end
    checks++; if (count10 !== 10'd25) begin errors++; $display("FAIL basic_count_hold: got %0d exp 25", count10); end
    checks++; if (busy10 !== 1'b0) begin errors++; $display("FAIL basic_busy_hold: got %b exp 0", busy10); end
    handshake();
    checks++; if (valid10 !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b exp 0", valid10); end
    checks++; if (state10 !== ST_IDLE) begin errors++; $display("FAIL basic_state_idle: got %0d exp %0d", state10, ST_IDLE); end
    checks++; if (result10 !== 10'd25) begin errors++; $display("FAIL basic_result_kept: got %0d exp 25", result10); end
  endtask

  task automatic test_gated_ticks();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      en = (i % 2 == 0);
      step();
    end
    en = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (result10 !== 10'd20) begin errors++; $display("FAIL gated_result: got %0d exp 20", result10); end
    checks++; if (overflow10 !== 1'b0) begin errors++; $display("FAIL gated_overflow: got %b exp 0", overflow10); end
    handshake();
  endtask

  task automatic test_saturation();
    logic exp_ovf4;
`ifdef ELAPSED_TIMEOUT_EN
    exp_ovf4 = 1'b0;  // narrow instance auto-stops at its threshold of 15 first
`else
    exp_ovf4 = 1'b1;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 20; i++) step();
    checks++; if (count4 !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d exp 15", count4); end
    checks++; if (count10 !== 10'd20) begin errors++; $display("FAIL sat_wide_count: got %0d exp 20", count10); end
    stop = 1'b1;
    step();
    stop = 1'b0; en = 1'b0;
    checks++; if (result4 !== 4'd15) begin errors++; $display("FAIL sat_result: got %0d exp 15", result4); end
    checks++; if (overflow4 !== exp_ovf4) begin errors++; $display("FAIL sat_overflow: got %b exp %b", overflow4, exp_ovf4); end
    checks++; if (count4 !== 4'd15) begin errors++; $display("FAIL sat_no_wrap: got %0d exp 15", count4); end
    checks++; if (result10 !== 10'd20 || overflow10 !== 1'b0) begin errors++; $display("FAIL sat_wide: got %0d/%b exp 20/0", result10, overflow10); end
    handshake();
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    en = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      step();
      checks++; if (valid10 !== 1'b1 || result10 !== 10'd5) begin errors++; $display("FAIL bp_stable[%0d]: got %b/%0d exp 1/5", i, valid10, result10); end
    end
    start = 1'b0;
    checks++; if (state10 !== ST_HOLD || busy10 !== 1'b0) begin errors++; $display("FAIL bp_start_ignored: got %0d/%b exp %0d/0", state10, busy10, ST_HOLD); end
    handshake();
    checks++; if (valid10 !== 1'b0) begin errors++; $display("FAIL bp_release: got %b exp 0", valid10); end
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if (state10 !== ST_RUN || busy10 !== 1'b1) begin errors++; $display("FAIL start_stop_prio: got %0d/%b exp %0d/1", state10, busy10, ST_RUN); end
    checks++; if (valid10 !== 1'b0) begin errors++; $display("FAIL start_stop_valid: got %b exp 0", valid10); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    handshake();
  endtask

  task automatic test_abort();
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 7; i++) step();
    en = 1'b0;
    checks++; if (count10 !== 10'd7) begin errors++; $display("FAIL abort_pre_count: got %0d exp 7", count10); end
    reset = 1'b0;
    #1;
    checks++; if ({count10, result10} !== 20'd0) begin errors++; $display("FAIL abort_reset_data: got %0d/%0d exp 0/0", count10, result10); end
    checks++; if ({valid10, overflow10, busy10} !== 3'b000 || state10 !== ST_IDLE) begin errors++; $display("FAIL abort_reset_flags: got %b st %0d exp 000 st 0", {valid10, overflow10, busy10}, state10); end
    #2;
    reset = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    en = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (valid10 !== 1'b1 || result10 !== 10'd3) begin errors++; $display("FAIL clear_pre_hold: got %b/%0d exp 1/3", valid10, result10); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (valid10 !== 1'b0 || state10 !== ST_IDLE) begin errors++; $display("FAIL clear_hold: got %b st %0d exp 0 st 0", valid10, state10); end
    checks++; if (result10 !== 10'd0 || count10 !== 10'd0) begin errors++; $display("FAIL clear_data: got %0d/%0d exp 0/0", result10, count10); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy10 !== 1'b1) begin errors++; $display("FAIL clear_restart: got %b exp 1", busy10); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (busy10 !== 1'b0 || state10 !== ST_IDLE) begin errors++; $display("FAIL clear_run: got %b st %0d exp 0 st 0", busy10, state10); end
  endtask

`ifdef ELAPSED_TIMEOUT_EN
  task automatic test_timeout();
    int waited;
    tv = 10'd12;
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1;
    waited = 0;
    while (valid10 !== 1'b1 && waited < 30) begin
      step();
      waited++;
    end
    en = 1'b0;
    checks++; if (waited !== 13) begin errors++; $display("FAIL timeout_latency: got %0d exp 13", waited); end
    checks++; if (result10 !== 10'd12 || timed_out10 !== 1'b1) begin errors++; $display("FAIL timeout_auto: got %0d/%b exp 12/1", result10, timed_out10); end
    handshake();
    checks++; if (timed_out10 !== 1'b0 || valid10 !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b/%b exp 0/0", timed_out10, valid10); end
    start = 1'b1;
    step();
    start = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 12; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0; en = 1'b0;
    checks++; if (result10 !== 10'd12 || timed_out10 !== 1'b0 || valid10 !== 1'b1) begin errors++; $display("FAIL timeout_stop_prio: got %0d/%b/%b exp 12/0/1", result10, timed_out10, valid10); end
    handshake();
    tv = 10'h3ff;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gated_ticks();
    test_saturation();
    test_back_to_back();
    test_abort();
`ifdef ELAPSED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elapsed_timer.md
Name: elapsed_timer

Overview:
- Up-counting complement of the game's countdown timers.
- Measures qualified ticks between a start event and a stop event, e.g. duck-appear to trigger-pull reaction time.
- Holds the captured value behind a valid/ready handshake until the scoring logic accepts it.
- Sits between the game-control FSM (start/stop/clear) and the score/update logic (result consumer).

Parameters:
- N, 10, width of the tick counter and of the result.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state.
- en  in  1  tick qualifier; the counter advances only on cycles with en=1.
- start  in  1  single-cycle pulse; begins a measurement.
- stop  in  1  single-cycle pulse; ends a measurement and captures the count.
- clear  in  1  synchronous abort; returns to IDLE from any state.
- count  out  N  live counter value.
- result  out  N  captured measurement.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- overflow  out  1  counter saturated during this measurement (sticky).
- busy  out  1  high in RUN.

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, result=0, result_valid=0, overflow=0, busy=0.
- States: IDLE, RUN, HOLD; encoded as enum from package.
- Priority each cycle: reset > clear > state logic.
- clear: next state IDLE; count=0, result=0, result_valid=0, overflow=0. A pending result is discarded.
- IDLE:
  - start=1 -> RUN; count<=0, overflow<=0.
  - stop ignored.
  - start and stop together -> start wins (enter RUN).
- RUN:
  - busy=1.
  - On en=1 with count<all-ones, count<=count+1.
  - On en=1 with count==all-ones, count holds and overflow<=1 (saturate, no wrap).
  - stop=1 -> HOLD; result<=count (pre-increment value, this cycle's en ignored); result_valid<=1.
  - start while in RUN is ignored (no restart).
- HOLD:
  - result_valid=1; result and count stable.
  - result_valid & result_ready -> IDLE next cycle; result_valid<=0. result retains its value.
  - start/stop ignored while in HOLD. The controller must wait until result_valid drops before issuing start.
- Latency:
  - start to busy: 1 cycle.
  - stop to result_valid: 1 cycle.
  - ready acceptance to IDLE: 1 cycle.
- result_valid must not drop without acceptance, except on clear or reset.
- Reset asserted mid-RUN or mid-HOLD: immediate return to reset values; no result emitted.

Optional Feature:
- Macro ELAPSED_TIMEOUT_EN.
- Defined:
  - Adds input timeout_val[N-1:0] and output timed_out (1 bit).
  - In RUN, if count==timeout_val on an en cycle, auto-stop: HOLD with result<=timeout_val, timed_out<=1.
  - timed_out stays high until the handshake completes or clear/reset.
  - An explicit stop in the same cycle takes precedence; timed_out stays 0.
  - timeout_val=0 with en=1 on the first RUN cycle gives result 0 and timed_out=1.
- Not defined: no extra ports; a measurement ends only on stop.

Decomposition:
- Package elapsed_timer_pkg:
  - state enum (IDLE, RUN, HOLD).
  - localparam for the saturation test (all-ones of width N, built from N).
- Sub-module sat_up_counter: parameter N; inputs clr and inc; outputs q and sat.
  - Owns the count register and saturation detect.
  - The FSM in elapsed_timer drives clr and inc.

Test Plan:
- Basic: reset release, start, en=1 for 25 cycles, stop -> result=25, result_valid=1 one cycle after stop; ready=1 -> IDLE, valid=0.
- Gated ticks: N=10, start, en toggling 1/0 over 40 cycles (20 high), stop -> result=20, overflow=0.
- Saturation: N=4, start, en=1 for 20 cycles, stop -> result=15, overflow=1, count holds at 15 with no wrap to 0.
- Back-pressure and priority: result_ready=0 for 10 cycles -> result_valid and result stable; start pulse in HOLD ignored; ready=1 -> IDLE. In IDLE, start and stop together -> RUN.
- Abort: reset=0 pulse mid-RUN at count=7 -> all outputs 0 immediately. Separately, clear in HOLD -> result_valid=0, IDLE next cycle.
- ELAPSED_TIMEOUT_EN: timeout_val=12, start, en=1 continuously -> HOLD with result=12, timed_out=1, no stop required. Repeat with stop at the count=12 cycle -> timed_out=0.
